// File: rtl/id_stage_fwd_if.sv
// Bundles every signal the decode stage exchanges with its neighbours:
// the IF handshake, the regfile read ports, the bypass network, the EX
// handshake, the branch redirect and the stall counter.
// The stage itself uses the slave modport.
// The environment (the pipeline or a testbench) uses the master modport.
interface id_stage_fwd_if #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int N_FWD = 3,
    parameter int CNT_W = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_pc;
    logic [31:0]           in_inst;
    logic [RAW-1:0]        rf_raddr1;
    logic [RAW-1:0]        rf_raddr2;
    logic [XLEN-1:0]       rf_rdata1;
    logic [XLEN-1:0]       rf_rdata2;
    logic [N_FWD-1:0]      fwd_we;
    logic [N_FWD*RAW-1:0]  fwd_waddr;
    logic [N_FWD*XLEN-1:0] fwd_wdata;
    logic [N_FWD-1:0]      fwd_pending;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_pc;
    logic [11:0]           out_alu_op;
    logic [XLEN-1:0]       out_src1;
    logic [XLEN-1:0]       out_src2;
    logic [XLEN-1:0]       out_st_data;
    logic                  out_mem_en;
    logic [3:0]            out_mem_wen;
    logic                  out_rf_we;
    logic [RAW-1:0]        out_rf_waddr;
    logic                  out_is_load;
    logic                  out_illegal;
    logic                  br_taken;
    logic [XLEN-1:0]       br_target;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output flush, in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2,
               fwd_we, fwd_waddr, fwd_wdata, fwd_pending, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_alu_op,
               out_src1, out_src2, out_st_data, out_mem_en, out_mem_wen,
               out_rf_we, out_rf_waddr, out_is_load, out_illegal,
               br_taken, br_target, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2,
               fwd_we, fwd_waddr, fwd_wdata, fwd_pending, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_alu_op,
               out_src1, out_src2, out_st_data, out_mem_en, out_mem_wen,
               out_rf_we, out_rf_waddr, out_is_load, out_illegal,
               br_taken, br_target, stall_cnt
    );
endinterface

// File: rtl/id_stage_fwd.sv
// MIPS32 integer-subset decode stage with an N-source bypass network,
// load-use hold and branch/jump resolution. It holds one instruction at a
// time. All outputs are combinational from the held instruction and the
// bypass inputs.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_RUN  | no load-use hazard; a held instruction is offered to EX
// S_HOLD | a read operand waits on a pending bypass result; EX sees
//        | nothing and IF is back-pressured
module id_stage_fwd #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int N_FWD = 3,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    id_stage_fwd_if.slave bus
);
    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SUB  = 12'h400;
    localparam logic [11:0] OP_SLT  = 12'h200;
    localparam logic [11:0] OP_SLTU = 12'h100;
    localparam logic [11:0] OP_AND  = 12'h080;
    localparam logic [11:0] OP_NOR  = 12'h040;
    localparam logic [11:0] OP_OR   = 12'h020;
    localparam logic [11:0] OP_XOR  = 12'h010;
    localparam logic [11:0] OP_SLL  = 12'h008;
    localparam logic [11:0] OP_SRL  = 12'h004;
    localparam logic [11:0] OP_SRA  = 12'h002;
    localparam logic [11:0] OP_LUI  = 12'h001;

    typedef enum logic {S_RUN, S_HOLD} state_t;
    typedef enum logic [1:0] {S1_ZERO, S1_RS, S1_SA, S1_PC} src1_sel_t;
    typedef enum logic [2:0] {S2_ZERO, S2_RT, S2_SIMM, S2_ZIMM, S2_EIGHT} src2_sel_t;

    state_t          state_q, state_d;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_inst;

    logic [5:0]      opc, fn;
    logic [RAW-1:0]  rs, rt;
    logic [4:0]      rd, sa;
    logic [15:0]     imm16;
    logic [25:0]     idx26;

    logic [11:0]     alu_op;
    logic            use_rs, use_rt, wr_en, mem_en, is_load, illegal;
    logic            is_beq, is_bne, is_jimm, is_jr, r_alu, r_shift, i_alu;
    logic [RAW-1:0]  dst;
    logic [3:0]      mem_wen;
    src1_sel_t       s1_sel;
    src2_sel_t       s2_sel;

    logic [XLEN-1:0] rs_val, rt_val, simm, zimm, pc4;
    logic            rs_pend, rt_pend, hazard, hold, fire, taken;
    logic [XLEN-1:0] src1, src2, target;

    assign opc   = id_inst[31:26];
    assign rs    = RAW'(id_inst[25:21]);
    assign rt    = RAW'(id_inst[20:16]);
    assign rd    = id_inst[15:11];
    assign sa    = id_inst[10:6];
    assign fn    = id_inst[5:0];
    assign imm16 = id_inst[15:0];
    assign idx26 = id_inst[25:0];
    assign simm  = {{(XLEN-16){imm16[15]}}, imm16};
    assign zimm  = {{(XLEN-16){1'b0}}, imm16};
    assign pc4   = id_pc + XLEN'(4);

    // Instruction decode into operand selects and control fields.
    always_comb begin
        alu_op  = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        wr_en   = 1'b0;
        dst     = '0;
        mem_en  = 1'b0;
        mem_wen = 4'b0000;
        is_load = 1'b0;
        illegal = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jimm = 1'b0;
        is_jr   = 1'b0;
        r_alu   = 1'b0;
        r_shift = 1'b0;
        i_alu   = 1'b0;
        s1_sel  = S1_ZERO;
        s2_sel  = S2_ZERO;
        case (opc)
            6'h00: begin
                case (fn)
                    6'h21: begin alu_op = OP_ADD;  r_alu = 1'b1; end
                    6'h23: begin alu_op = OP_SUB;  r_alu = 1'b1; end
                    6'h24: begin alu_op = OP_AND;  r_alu = 1'b1; end
                    6'h25: begin alu_op = OP_OR;   r_alu = 1'b1; end
                    6'h26: begin alu_op = OP_XOR;  r_alu = 1'b1; end
                    6'h27: begin alu_op = OP_NOR;  r_alu = 1'b1; end
                    6'h2A: begin alu_op = OP_SLT;  r_alu = 1'b1; end
                    6'h2B: begin alu_op = OP_SLTU; r_alu = 1'b1; end
                    6'h00: begin alu_op = OP_SLL;  r_shift = 1'b1; end
                    6'h02: begin alu_op = OP_SRL;  r_shift = 1'b1; end
                    6'h03: begin alu_op = OP_SRA;  r_shift = 1'b1; end
                    6'h08: begin
                        is_jr  = 1'b1;
                        use_rs = 1'b1;
                        s1_sel = S1_RS;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            6'h09: begin alu_op = OP_ADD;  i_alu = 1'b1; s2_sel = S2_SIMM; end
            6'h0A: begin alu_op = OP_SLT;  i_alu = 1'b1; s2_sel = S2_SIMM; end
            6'h0B: begin alu_op = OP_SLTU; i_alu = 1'b1; s2_sel = S2_SIMM; end
            6'h0C: begin alu_op = OP_AND;  i_alu = 1'b1; s2_sel = S2_ZIMM; end
            6'h0D: begin alu_op = OP_OR;   i_alu = 1'b1; s2_sel = S2_ZIMM; end
            6'h0E: begin alu_op = OP_XOR;  i_alu = 1'b1; s2_sel = S2_ZIMM; end
            6'h0F: begin
                alu_op = OP_LUI;
                s2_sel = S2_SIMM;
                wr_en  = 1'b1;
                dst    = rt;
            end
            6'h04, 6'h05: begin
                is_beq = (opc == 6'h04);
                is_bne = (opc == 6'h05);
                use_rs = 1'b1;
                use_rt = 1'b1;
                s1_sel = S1_RS;
                s2_sel = S2_RT;
            end
            6'h02: is_jimm = 1'b1;
            6'h03: begin
                is_jimm = 1'b1;
                alu_op  = OP_ADD;
                s1_sel  = S1_PC;
                s2_sel  = S2_EIGHT;
                wr_en   = 1'b1;
                dst     = RAW'(31);
            end
            6'h23: begin
                alu_op  = OP_ADD;
                use_rs  = 1'b1;
                s1_sel  = S1_RS;
                s2_sel  = S2_SIMM;
                mem_en  = 1'b1;
                is_load = 1'b1;
                wr_en   = 1'b1;
                dst     = rt;
            end
            6'h2B: begin
                alu_op  = OP_ADD;
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                s1_sel  = S1_RS;
                s2_sel  = S2_SIMM;
                mem_en  = 1'b1;
                mem_wen = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
        if (r_alu) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            s1_sel = S1_RS;
            s2_sel = S2_RT;
            wr_en  = 1'b1;
            dst    = RAW'(rd);
        end
        if (r_shift) begin
            use_rt = 1'b1;
            s1_sel = S1_SA;
            s2_sel = S2_RT;
            wr_en  = 1'b1;
            dst    = RAW'(rd);
        end
        if (i_alu) begin
            use_rs = 1'b1;
            s1_sel = S1_RS;
            wr_en  = 1'b1;
            dst    = rt;
        end
    end

    // Bypass resolution: the loop runs oldest to youngest, so the lowest
    // matching index is written last and wins. Register 0 never matches.
    always_comb begin
        rs_val  = (rs == '0) ? '0 : bus.rf_rdata1;
        rt_val  = (rt == '0) ? '0 : bus.rf_rdata2;
        rs_pend = 1'b0;
        rt_pend = 1'b0;
        for (int k = N_FWD - 1; k >= 0; k--) begin
            if (bus.fwd_we[k] && (bus.fwd_waddr[k*RAW +: RAW] == rs) && (rs != '0)) begin
                rs_val  = bus.fwd_wdata[k*XLEN +: XLEN];
                rs_pend = bus.fwd_pending[k];
            end
            if (bus.fwd_we[k] && (bus.fwd_waddr[k*RAW +: RAW] == rt) && (rt != '0)) begin
                rt_val  = bus.fwd_wdata[k*XLEN +: XLEN];
                rt_pend = bus.fwd_pending[k];
            end
        end
    end

    assign hazard = id_valid && ((use_rs && rs_pend) || (use_rt && rt_pend));

    // Hold/run state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    // Next state; the hold decision follows the current hazard with no lag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (hazard)  state_d = S_HOLD;
            S_HOLD:  if (!hazard) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    assign hold = (state_d == S_HOLD);
    assign fire = bus.out_valid && bus.out_ready;

    // ID register; flush wins over a simultaneous load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
        end else if (bus.flush) begin
            id_valid <= 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
            id_valid <= 1'b1;
            id_pc    <= bus.in_pc;
            id_inst  <= bus.in_inst;
        end else if (fire) begin
            id_valid <= 1'b0;
        end
    end

    // Load-use stall counter; saturates and survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    bus.stall_cnt <= '0;
        else if (hold && (bus.stall_cnt != '1))     bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
    end

    // Operand muxes, branch condition and redirect target.
    always_comb begin
        src1   = '0;
        src2   = '0;
        taken  = 1'b0;
        target = '0;
        case (s1_sel)
            S1_RS:   src1 = rs_val;
            S1_SA:   src1 = {{(XLEN-5){1'b0}}, sa};
            S1_PC:   src1 = id_pc;
            default: src1 = '0;
        endcase
        case (s2_sel)
            S2_RT:    src2 = rt_val;
            S2_SIMM:  src2 = simm;
            S2_ZIMM:  src2 = zimm;
            S2_EIGHT: src2 = XLEN'(8);
            default:  src2 = '0;
        endcase
        if (is_beq && (rs_val == rt_val)) begin
            taken  = 1'b1;
            target = pc4 + (simm << 2);
        end else if (is_bne && (rs_val != rt_val)) begin
            taken  = 1'b1;
            target = pc4 + (simm << 2);
        end else if (is_jimm) begin
            taken  = 1'b1;
            target = {pc4[XLEN-1:28], idx26, 2'b00};
        end else if (is_jr) begin
            taken  = 1'b1;
            target = rs_val;
        end
    end

    assign bus.in_ready     = !id_valid || fire;
    assign bus.out_valid    = id_valid && !hold;
    assign bus.rf_raddr1    = rs;
    assign bus.rf_raddr2    = rt;
    assign bus.out_pc       = id_pc;
    assign bus.out_alu_op   = alu_op;
    assign bus.out_src1     = src1;
    assign bus.out_src2     = src2;
    assign bus.out_st_data  = rt_val;
    assign bus.out_mem_en   = mem_en;
    assign bus.out_mem_wen  = mem_wen;
    assign bus.out_rf_we    = wr_en && (dst != '0);
    assign bus.out_rf_waddr = dst;
    assign bus.out_is_load  = is_load;
    assign bus.out_illegal  = illegal;
    assign bus.br_taken     = fire && taken;
    assign bus.br_target    = (fire && taken) ? target : '0;
endmodule
